// File: rtl/get_param_bt_if.sv
// Request, result and register-file read bundle for get_param_bt.
// The master side issues fetches and serves reads; the slave side is the fetcher.
interface get_param_bt_if #(
    parameter int unsigned PW    = 8,
    parameter int unsigned AW    = 12,
    parameter int unsigned POS_W = 5
);
    logic                  start;
    logic [AW-1:0]         start_addr;
    logic                  busy;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [4*PW-1:0]       rd_param;
    logic [POS_W+AW:0]     rd_state;
    logic                  valid;
    logic                  found;
    logic                  exhausted;
    logic                  err_hops;
    logic [PW-1:0]         i_out;
    logic [PW-1:0]         z_out;
    logic [PW-1:0]         k_out;
    logic [PW-1:0]         l_out;
    logic [AW-1:0]         addr_out;
    logic [POS_W-1:0]      position_out;

    modport master (
        output start, start_addr, rd_param, rd_state,
        input  busy, rd_en, rd_addr, valid, found, exhausted, err_hops,
        input  i_out, z_out, k_out, l_out, addr_out, position_out
    );

    modport slave (
        input  start, start_addr, rd_param, rd_state,
        output busy, rd_en, rd_addr, valid, found, exhausted, err_hops,
        output i_out, z_out, k_out, l_out, addr_out, position_out
    );
endinterface

// File: rtl/get_param_bt.sv
// Inexact-recursion parameter fetcher: walks parent back-pointers from start_addr to the first
// unfinished entry. Optional GET_PARAM_BT_STATS_EN adds hops_last_o / fetch_cnt_o statistics.
module get_param_bt #(
    parameter int unsigned PW        = 8,
    parameter int unsigned AW        = 12,
    parameter int unsigned POS_W     = 5,
    parameter int unsigned MAX_HOPS  = 64,
    parameter int unsigned ROOT_ADDR = 0,
    localparam int unsigned HW       = $clog2(MAX_HOPS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef GET_PARAM_BT_STATS_EN
    output logic [HW-1:0]   hops_last_o,
    output logic [31:0]     fetch_cnt_o,
`endif
    get_param_bt_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cur_addr_q, cur_addr_d;
    logic [HW-1:0]     hops_q, hops_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              valid_q, valid_d;
    logic              found_q, found_d;
    logic              exhausted_q, exhausted_d;
    logic              err_hops_q, err_hops_d;
    logic [4*PW-1:0]   param_q, param_d;
    logic [AW-1:0]     addr_out_q, addr_out_d;
    logic [POS_W-1:0]  pos_q, pos_d;

    logic              st_over;
    logic [AW-1:0]     st_parent;
    logic [POS_W-1:0]  st_pos;

    assign st_over   = bus.rd_state[0];
    assign st_parent = bus.rd_state[AW:1];
    assign st_pos    = bus.rd_state[POS_W+AW -: POS_W];

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        hops_d      = hops_q;
        busy_d      = busy_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        valid_d     = 1'b0;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        err_hops_d  = err_hops_q;
        param_d     = param_q;
        addr_out_d  = addr_out_q;
        pos_d       = pos_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StIssue;
                    cur_addr_d  = bus.start_addr;
                    hops_d      = '0;
                    busy_d      = 1'b1;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = bus.start_addr;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    err_hops_d  = 1'b0;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (!st_over) begin
                    state_d    = StDone;
                    valid_d    = 1'b1;
                    found_d    = 1'b1;
                    param_d    = bus.rd_param;
                    addr_out_d = cur_addr_q;
                    pos_d      = st_pos;
                end else if (cur_addr_q == AW'(ROOT_ADDR)) begin
                    state_d     = StDone;
                    valid_d     = 1'b1;
                    exhausted_d = 1'b1;
                    param_d     = '0;
                    addr_out_d  = '0;
                    pos_d       = '0;
                end else if (hops_q == HW'(MAX_HOPS)) begin
                    state_d    = StDone;
                    valid_d    = 1'b1;
                    err_hops_d = 1'b1;
                    param_d    = '0;
                    addr_out_d = '0;
                    pos_d      = '0;
                end else begin
                    // Follow the back-pointer; the read is issued in the next cycle.
                    state_d    = StIssue;
                    cur_addr_d = st_parent;
                    hops_d     = hops_q + HW'(1);
                    rd_en_d    = 1'b1;
                    rd_addr_d  = st_parent;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            hops_q      <= '0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            valid_q     <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            err_hops_q  <= 1'b0;
            param_q     <= '0;
            addr_out_q  <= '0;
            pos_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            hops_q      <= hops_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            valid_q     <= valid_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            err_hops_q  <= err_hops_d;
            param_q     <= param_d;
            addr_out_q  <= addr_out_d;
            pos_q       <= pos_d;
        end
    end

`ifdef GET_PARAM_BT_STATS_EN
    logic [HW-1:0] hops_last_q;
    logic [31:0]   fetch_cnt_q;

    // Updated alongside the result so both are visible in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hops_last_q <= '0;
            fetch_cnt_q <= '0;
        end else if (valid_d) begin
            hops_last_q <= hops_q;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign hops_last_o = hops_last_q;
    assign fetch_cnt_o = fetch_cnt_q;
`endif

    assign bus.busy         = busy_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.valid        = valid_q;
    assign bus.found        = found_q;
    assign bus.exhausted    = exhausted_q;
    assign bus.err_hops     = err_hops_q;
    assign bus.i_out        = param_q[4*PW-1 -: PW];
    assign bus.z_out        = param_q[3*PW-1 -: PW];
    assign bus.k_out        = param_q[2*PW-1 -: PW];
    assign bus.l_out        = param_q[PW-1 -: PW];
    assign bus.addr_out     = addr_out_q;
    assign bus.position_out = pos_q;

endmodule

// File: tb/tb_get_param_bt.sv
// Directed bench for get_param_bt: default instance plus a MAX_HOPS=4 instance for the hop guard,
// both served by one registered register-file model.
module tb_get_param_bt;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    get_param_bt_if #(.PW(8), .AW(12), .POS_W(5)) if0 ();
    get_param_bt_if #(.PW(8), .AW(12), .POS_W(5)) if1 ();

`ifdef GET_PARAM_BT_STATS_EN
    logic [6:0]  hl0;
    logic [2:0]  hl1;
    logic [31:0] fc0, fc1;
`endif

    get_param_bt #(.MAX_HOPS(64)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef GET_PARAM_BT_STATS_EN
        .hops_last_o (hl0),
        .fetch_cnt_o (fc0),
`endif
        .bus   (if0)
    );

    get_param_bt #(.MAX_HOPS(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef GET_PARAM_BT_STATS_EN
        .hops_last_o (hl1),
        .fetch_cnt_o (fc1),
`endif
        .bus   (if1)
    );

    logic [31:0] mem_param [4096];
    logic [17:0] mem_state [4096];

    always @(posedge clk) begin
        if (if0.rd_en) begin
            if0.rd_param <= mem_param[if0.rd_addr];
            if0.rd_state <= mem_state[if0.rd_addr];
        end
        if (if1.rd_en) begin
            if1.rd_param <= mem_param[if1.rd_addr];
            if1.rd_state <= mem_state[if1.rd_addr];
        end
    end

    logic [11:0] rd_log0[$];
    logic [11:0] rd_log1[$];
    int valid_cnt0 = 0;

    always @(negedge clk) begin
        if (if0.rd_en) rd_log0.push_back(if0.rd_addr);
        if (if1.rd_en) rd_log1.push_back(if1.rd_addr);
        if (if0.valid) valid_cnt0++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] mk_state(input logic [4:0] pos, input logic [11:0] parent,
                                             input logic over);
        return {pos, parent, over};
    endfunction

    // Start in the current cycle T; returns with the bench in the valid cycle (or at the bound).
    task automatic fetch0(input string tag, input logic [11:0] a, output int lat);
        rd_log0.delete();
        if0.start = 1'b1;
        if0.start_addr = a;
        tick();
        if0.start = 1'b0;
        check({tag, " rd_en@T+1"}, 64'(if0.rd_en), 64'd1);
        check({tag, " rd_addr@T+1"}, 64'(if0.rd_addr), 64'(a));
        check({tag, " busy@T+1"}, 64'(if0.busy), 64'd1);
        lat = 1;
        while (!if0.valid && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        int          lat;
        logic [2:0]  flags;   // {found, exhausted, err_hops}
        logic [31:0] param;
        logic [11:0] oaddr;
        logic [4:0]  pos;
        int          reads;
        logic [11:0] last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int v0;
        string tag;

        for (int a = 0; a < 4096; a++) begin
            mem_param[a] = 32'h0;
            mem_state[a] = 18'h0;
        end
        mem_param[12'h000] = 32'h0;       mem_state[12'h000] = mk_state(5'd0, 12'h000, 1'b1);
        mem_param[12'h010] = 32'h01020304; mem_state[12'h010] = mk_state(5'd5, 12'h000, 1'b0);
        mem_param[12'h030] = 32'h11111111; mem_state[12'h030] = mk_state(5'd1, 12'h020, 1'b1);
        mem_param[12'h020] = 32'h22222222; mem_state[12'h020] = mk_state(5'd2, 12'h008, 1'b1);
        mem_param[12'h008] = 32'hAABBCCDD; mem_state[12'h008] = mk_state(5'd3, 12'h000, 1'b0);
        mem_param[12'h005] = 32'h55555555; mem_state[12'h005] = mk_state(5'd7, 12'h000, 1'b1);
        mem_param[12'h040] = 32'h0;       mem_state[12'h040] = mk_state(5'd0, 12'h000, 1'b0);
        mem_param[12'h050] = 32'h50505050; mem_state[12'h050] = mk_state(5'd9, 12'h040, 1'b1);
        mem_param[12'h070] = 32'h77777777; mem_state[12'h070] = mk_state(5'd4, 12'h070, 1'b1);
        mem_param[12'h007] = 32'h07070707; mem_state[12'h007] = mk_state(5'd6, 12'h007, 1'b1);

        vecs[0] = '{12'h010, 3,   3'b100, 32'hAABBCCDD ^ 32'hABB9CFD9, 12'h010, 5'd5, 1,  12'h010};
        vecs[1] = '{12'h030, 7,   3'b100, 32'hAABBCCDD, 12'h008, 5'd3, 3,  12'h008};
        vecs[2] = '{12'h005, 5,   3'b010, 32'h0,        12'h000, 5'd0, 2,  12'h000};
        vecs[3] = '{12'h000, 3,   3'b010, 32'h0,        12'h000, 5'd0, 1,  12'h000};
        vecs[4] = '{12'h050, 5,   3'b100, 32'h0,        12'h040, 5'd0, 2,  12'h040};
        vecs[5] = '{12'h070, 131, 3'b001, 32'h0,        12'h000, 5'd0, 65, 12'h070};

        if0.start = 1'b0; if0.start_addr = '0;
        if1.start = 1'b0; if1.start_addr = '0;

        rst_n = 1'b0;
        repeat (3) tick();
        check("reset outputs dut0",
              64'({if0.busy, if0.rd_en, if0.rd_addr, if0.valid, if0.found, if0.exhausted,
                   if0.err_hops, if0.i_out, if0.z_out, if0.k_out, if0.l_out}), 64'd0);
        check("reset addr/pos dut0", 64'({if0.addr_out, if0.position_out}), 64'd0);
        check("reset outputs dut1",
              64'({if1.busy, if1.rd_en, if1.valid, if1.found, if1.exhausted, if1.err_hops}),
              64'd0);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 6; n++) begin
            tag = $sformatf("vec%0d", n);
            fetch0(tag, vecs[n].addr, lat);
            check({tag, " latency"}, 64'(lat), 64'(vecs[n].lat));
            check({tag, " flags"}, 64'({if0.found, if0.exhausted, if0.err_hops}),
                  64'(vecs[n].flags));
            check({tag, " izkl"}, 64'({if0.i_out, if0.z_out, if0.k_out, if0.l_out}),
                  64'(vecs[n].param));
            check({tag, " addr_out"}, 64'(if0.addr_out), 64'(vecs[n].oaddr));
            check({tag, " position_out"}, 64'(if0.position_out), 64'(vecs[n].pos));
            check({tag, " busy@valid"}, 64'(if0.busy), 64'd1);
            check({tag, " reads"}, 64'(rd_log0.size()), 64'(vecs[n].reads));
            if (rd_log0.size() > 0)
                check({tag, " last read"}, 64'(rd_log0[$]), 64'(vecs[n].last));
            tick();
            check({tag, " valid falls"}, 64'(if0.valid), 64'd0);
            check({tag, " busy falls"}, 64'(if0.busy), 64'd0);
            check({tag, " flags hold"}, 64'({if0.found, if0.exhausted, if0.err_hops}),
                  64'(vecs[n].flags));
        end

        // Two-hop fetch with start pulses at T+2 and in the DONE cycle, both ignored.
        rd_log0.delete();
        if0.start = 1'b1; if0.start_addr = 12'h030;
        tick();
        if0.start = 1'b0;
        tick();
        if0.start = 1'b1; if0.start_addr = 12'h010;
        tick();
        if0.start = 1'b0;
        lat = 3;
        while (!if0.valid && lat < 400) begin
            tick();
            lat++;
        end
        check("busy-start latency", 64'(lat), 64'd7);
        check("busy-start addr_out", 64'(if0.addr_out), 64'h008);
        check("busy-start izkl", 64'({if0.i_out, if0.z_out, if0.k_out, if0.l_out}),
              64'hAABBCCDD);
        check("busy-start reads", 64'(rd_log0.size()), 64'd3);
        if (rd_log0.size() == 3) begin
            check("busy-start rd0", 64'(rd_log0[0]), 64'h030);
            check("busy-start rd1", 64'(rd_log0[1]), 64'h020);
            check("busy-start rd2", 64'(rd_log0[2]), 64'h008);
        end
        if0.start = 1'b1; if0.start_addr = 12'h010;
        tick();
        if0.start = 1'b0;
        check("done-start ignored rd_en", 64'(if0.rd_en), 64'd0);
        tick();
        check("done-start ignored rd_en2", 64'(if0.rd_en), 64'd0);
        check("done-start ignored busy", 64'(if0.busy), 64'd0);
        check("done-start result held", 64'({if0.found, if0.addr_out}), 64'h1008);

        // Reset in cycle T+4 of a two-hop fetch.
        if0.start = 1'b1; if0.start_addr = 12'h030;
        tick();
        if0.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("mid-reset outputs",
              64'({if0.busy, if0.rd_en, if0.rd_addr, if0.valid, if0.found, if0.exhausted,
                   if0.err_hops, if0.i_out, if0.z_out, if0.k_out, if0.l_out}), 64'd0);
        check("mid-reset addr/pos", 64'({if0.addr_out, if0.position_out}), 64'd0);
        rst_n = 1'b1;
        v0 = valid_cnt0;
        repeat (10) tick();
        check("no valid after reset", 64'(valid_cnt0 - v0), 64'd0);

        fetch0("restart", 12'h010, lat);
        check("restart latency", 64'(lat), 64'd3);
        check("restart found", 64'(if0.found), 64'd1);
        check("restart izkl", 64'({if0.i_out, if0.z_out, if0.k_out, if0.l_out}), 64'h01020304);
`ifdef GET_PARAM_BT_STATS_EN
        check("stats hops_last 0", 64'(hl0), 64'd0);
`endif
        tick();
        fetch0("restart2", 12'h030, lat);
        check("restart2 latency", 64'(lat), 64'd7);
`ifdef GET_PARAM_BT_STATS_EN
        check("stats hops_last 2", 64'(hl0), 64'd2);
        tick();
        check("stats fetch_cnt", 64'(fc0), 64'd2);
`else
        tick();
`endif

        // Hop guard on the MAX_HOPS=4 instance: self-looping entry.
        rd_log1.delete();
        if1.start = 1'b1; if1.start_addr = 12'h007;
        tick();
        if1.start = 1'b0;
        check("guard rd_en@T+1", 64'(if1.rd_en), 64'd1);
        lat = 1;
        while (!if1.valid && lat < 400) begin
            tick();
            lat++;
        end
        check("guard latency", 64'(lat), 64'd11);
        check("guard flags", 64'({if1.found, if1.exhausted, if1.err_hops}), 64'b001);
        check("guard data", 64'({if1.i_out, if1.z_out, if1.k_out, if1.l_out}), 64'd0);
        check("guard reads", 64'(rd_log1.size()), 64'd5);
        for (int r = 0; r < rd_log1.size(); r++)
            check($sformatf("guard rd%0d", r), 64'(rd_log1[r]), 64'h007);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/get_param_bt.md
Name: get_param_bt

Overview:
- Parametrised successor of the inexact-recursion parameter fetcher.
- On `start`, reads the entry at `start_addr` from the InexRecur/state register files. If the entry's `over` flag is set, it follows the parent back-pointer until it reaches an unfinished entry, the root, or the hop limit.
- Presents the found (i,z,k,l) tuple, its address and its execution position to the recursion-step logic through a registered one-cycle `valid` pulse.
- Unlike its predecessor, it has an explicit start/done handshake, a registered memory-read interface, root-exhaustion detection and a hop-limit guard.

Parameters:
- PW, 8: width of each of i, z, k, l.
- AW, 12: register-file address width.
- POS_W, 5: execution-position field width.
- MAX_HOPS, 64: maximum number of back-pointer hops before error.
- ROOT_ADDR, 0: address of the recursion root entry.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  begin a fetch; sampled only in IDLE
- start_addr  in  AW  address of the current (sequential) entry
- busy  out  1  high from the cycle after accepted `start` until the cycle `valid` is high, inclusive
- rd_en  out  1  read strobe to both register files
- rd_addr  out  AW  read address, shared by both register files
- rd_param  in  4*PW  {i,z,k,l}, MSB first; valid the cycle after `rd_en`
- rd_state  in  POS_W+AW+1  {position, parent_addr, over}; valid the cycle after `rd_en`
- valid  out  1  one-cycle result strobe
- found  out  1  unfinished entry located
- exhausted  out  1  root reached with `over`=1
- err_hops  out  1  MAX_HOPS exceeded
- i_out, z_out, k_out, l_out  out  PW each  parameters of the found entry
- addr_out  out  AW  address of the found entry
- position_out  out  POS_W  position field of the found entry

Behaviour:
- Reset: `rst_n` is synchronous and active-low; clock is `clk`. While `rst_n`=0, all outputs are 0 and the FSM is in IDLE with the hop counter at 0. Reset mid-fetch abandons the fetch; no `valid` is produced.
- All outputs are registered. `rd_addr` holds its last value when `rd_en`=0.
- IDLE: on `start`=1, latch `start_addr` into the current address, clear the hop counter, and go to ISSUE.
- ISSUE: `rd_en`=1 and `rd_addr`=current address for exactly this cycle. Next state is WAIT.
- WAIT: `rd_param`/`rd_state` are valid this cycle. Evaluate in priority order:
  1. `over`=0: load i/z/k/l_out, `addr_out`=current address, `position_out`; `found`=1; go to DONE.
  2. `over`=1 and current address == ROOT_ADDR: `exhausted`=1; data outputs are 0; go to DONE.
  3. `over`=1 and hop counter == MAX_HOPS: `err_hops`=1; data outputs are 0; go to DONE.
  4. Otherwise: current address ← `parent_addr`, hop counter +1, go to ISSUE.
- DONE: `valid`=1 for one cycle; exactly one of `found`/`exhausted`/`err_hops` is 1. Next state is IDLE.
- Flag and data hold: `found`/`exhausted`/`err_hops` and the data outputs hold their values until the next accepted `start`, which clears the flags.
- Latency: with `start` at cycle T, `rd_en` is at T+1 and `valid` is at T+3+2h, where h is the number of hops taken.
- `start` outside IDLE, including during DONE, is ignored. `start` in the same cycle `valid` falls is accepted normally.
- Hop counter width is clog2(MAX_HOPS+1); it never wraps.
- A `parent_addr` equal to the current address with `over`=1 is not special-cased; it terminates via the hop guard.
- A tuple of all zeros is legal data.

Optional Feature:
- Macro: `GET_PARAM_BT_STATS_EN`.
- Defined: adds outputs `hops_last` (clog2(MAX_HOPS+1) bits, the hop count of the last fetch, updated in the DONE cycle) and `fetch_cnt` (32 bits, increments on each `valid`, wraps modulo 2^32). Both reset to 0.
- Undefined: neither port exists and no extra logic is built. Core behaviour and timing are identical either way.

Test Plan:
- Direct hit: defaults; mem[0x010] = param 0x0102_0304, state {pos=5, parent=0x000, over=0}; start_addr=0x010 → `rd_addr`=0x010 at T+1; `valid` at T+3 with i=1, z=2, k=3, l=4, addr_out=0x010, position_out=5, found=1.
- Two-hop backtrack: 0x030 over=1 parent 0x020; 0x020 over=1 parent 0x008; 0x008 over=0 with pos=3 and param 0xAABBCCDD → `rd_addr` sequence 0x030, 0x020, 0x008; `valid` at T+7; addr_out=0x008; i=0xAA, z=0xBB, k=0xCC, l=0xDD; position_out=3.
- Root exhaustion: 0x005 over=1 parent 0x000; 0x000 over=1 → `valid` at T+5; exhausted=1, found=0, all data outputs 0.
- Hop guard: MAX_HOPS=4; 0x007 over=1 parent 0x007 → 5 reads of 0x007; `valid` at T+11 with err_hops=1.
- Start while busy and reset mid-fetch: pulse `start` at T+2 during the two-hop case → ignored, result unchanged. Assert `rst_n`=0 at T+4 → all outputs 0 next cycle, no `valid`. Re-`start` afterwards succeeds.
- Stats (`GET_PARAM_BT_STATS_EN`): run the direct-hit case, then the two-hop case → hops_last=0 then 2; fetch_cnt=2.
